// File: rtl/frame_detection.sv
// Delay-and-correlate OFDM short-preamble detector; samples pass through with 4-cycle latency.
// Define FD_ENERGY_GATE_EN to also require window energy P >= PWR_MIN before a cycle qualifies.
module frame_detection #(
   parameter int LAG       = 16,
   parameter int WIN       = 16,
   parameter int THR       = 6,
   parameter int HOLD      = 24,
   parameter int FRAME_LEN = 640,
   parameter int PWR_MIN   = 64
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic signed [7:0] bitInR,
   input  logic signed [7:0] bitInI,
   output logic              FrameEnable,
   output logic signed [7:0] bitOutR,
   output logic signed [7:0] bitOutI
);

   localparam int LAT      = 4;
   localparam int FILL_MAX = LAG + WIN + 1;
   localparam int FILL_W   = $clog2(FILL_MAX + 1);
   localparam int RUN_W    = ($clog2(HOLD + 1) > 5) ? $clog2(HOLD + 1) : 5;
   localparam int FRM_W    = $clog2(FRAME_LEN);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      REARM = 2'd2
   } state_t;

   logic signed [7:0]  r_out_r [LAT];
   logic signed [7:0]  r_out_i [LAT];
   logic signed [7:0]  r_dly_r [LAG];
   logic signed [7:0]  r_dly_i [LAG];
   logic signed [16:0] r_pr;
   logic signed [16:0] r_pi;
   logic [15:0]        r_e;
   logic signed [16:0] r_hist_pr [WIN];
   logic signed [16:0] r_hist_pi [WIN];
   logic [15:0]        r_hist_e  [WIN];
   logic signed [20:0] r_cr;
   logic signed [20:0] r_ci;
   logic [20:0]        r_p;
   logic [FILL_W-1:0]  r_fill;
   logic [RUN_W-1:0]   r_run_cnt;
   logic [FRM_W-1:0]   r_frm_cnt;
   state_t             r_state;

   logic signed [16:0] w_xr, w_xi, w_yr, w_yi;
   logic signed [16:0] w_pr, w_pi, w_esq;
   logic [15:0]        w_e;
   logic signed [21:0] w_cr22, w_ci22;
   logic [21:0]        w_abs_cr, w_abs_ci, w_m;
   logic [24:0]        w_lhs, w_rhs;
   logic               w_trusted;
   logic               w_qual;
   state_t             w_state_next;

   // NOTE: every register below uses non-blocking assignment so all stages see pre-edge values.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int k = 0; k < LAT; k++) begin
            r_out_r[k] <= '0;
            r_out_i[k] <= '0;
         end
      end else begin
         r_out_r[0] <= bitInR;
         r_out_i[0] <= bitInI;
         for (int k = 1; k < LAT; k++) begin
            r_out_r[k] <= r_out_r[k-1];
            r_out_i[k] <= r_out_i[k-1];
         end
      end
   end

   assign bitOutR = r_out_r[LAT-1];
   assign bitOutI = r_out_i[LAT-1];

   // NOTE: the delay line and histories are reset explicitly so detection restarts from an empty window.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int k = 0; k < LAG; k++) begin
            r_dly_r[k] <= '0;
            r_dly_i[k] <= '0;
         end
      end else begin
         r_dly_r[0] <= bitInR;
         r_dly_i[0] <= bitInI;
         for (int k = 1; k < LAG; k++) begin
            r_dly_r[k] <= r_dly_r[k-1];
            r_dly_i[k] <= r_dly_i[k-1];
         end
      end
   end

   // p(n) = x(n) * conj(x(n-LAG)), e(n) = |x(n-LAG)|^2
   always_comb begin
      w_xr  = 17'(bitInR);
      w_xi  = 17'(bitInI);
      w_yr  = 17'(r_dly_r[LAG-1]);
      w_yi  = 17'(r_dly_i[LAG-1]);
      w_pr  = w_xr * w_yr + w_xi * w_yi;
      w_pi  = w_xi * w_yr - w_xr * w_yi;
      w_esq = w_yr * w_yr + w_yi * w_yi;
      w_e   = 16'(w_esq);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_pr <= '0;
         r_pi <= '0;
         r_e  <= '0;
      end else begin
         r_pr <= w_pr;
         r_pi <= w_pi;
         r_e  <= w_e;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int k = 0; k < WIN; k++) begin
            r_hist_pr[k] <= '0;
            r_hist_pi[k] <= '0;
            r_hist_e[k]  <= '0;
         end
         r_cr <= '0;
         r_ci <= '0;
         r_p  <= '0;
      end else begin
         r_hist_pr[0] <= r_pr;
         r_hist_pi[0] <= r_pi;
         r_hist_e[0]  <= r_e;
         for (int k = 1; k < WIN; k++) begin
            r_hist_pr[k] <= r_hist_pr[k-1];
            r_hist_pi[k] <= r_hist_pi[k-1];
            r_hist_e[k]  <= r_hist_e[k-1];
         end
         r_cr <= r_cr + 21'(r_pr) - 21'(r_hist_pr[WIN-1]);
         r_ci <= r_ci + 21'(r_pi) - 21'(r_hist_pi[WIN-1]);
         r_p  <= r_p + 21'(r_e) - 21'(r_hist_e[WIN-1]);
      end
   end

   // Counts accepted samples; sums become trustworthy once LAG+WIN samples feed the current window.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_fill <= '0;
      end else if (r_fill != FILL_W'(FILL_MAX)) begin
         r_fill <= r_fill + 1'b1;
      end
   end

   always_comb begin
      w_cr22    = 22'(r_cr);
      w_ci22    = 22'(r_ci);
      w_abs_cr  = w_cr22[21] ? 22'(-w_cr22) : 22'(w_cr22);
      w_abs_ci  = w_ci22[21] ? 22'(-w_ci22) : 22'(w_ci22);
      w_m       = w_abs_cr + w_abs_ci;
      w_lhs     = {w_m, 3'b000};
      w_rhs     = 25'(r_p) * 25'(THR);
      w_trusted = (r_fill == FILL_W'(FILL_MAX));
`ifdef FD_ENERGY_GATE_EN
      w_qual    = w_trusted && (r_p != '0) && (w_lhs >= w_rhs) && (r_p >= 21'(PWR_MIN));
`else
      w_qual    = w_trusted && (r_p != '0) && (w_lhs >= w_rhs);
`endif
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_qual && (r_run_cnt == RUN_W'(HOLD - 1))) w_state_next = FRAME;
         FRAME:   if (r_frm_cnt == FRM_W'(FRAME_LEN - 1))       w_state_next = REARM;
         REARM:   if (!w_qual)                                   w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst || (r_state != IDLE) || !w_qual) begin
         r_run_cnt <= '0;
      end else begin
         r_run_cnt <= r_run_cnt + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst || (r_state != FRAME)) begin
         r_frm_cnt <= '0;
      end else begin
         r_frm_cnt <= r_frm_cnt + 1'b1;
      end
   end

   always_comb begin
      FrameEnable = (r_state == FRAME);
   end

endmodule

// File: tb/tb_frame_detection.sv
// Directed bench for frame_detection: per-cycle checks of the 4-cycle passthrough and FrameEnable window.
module tb_frame_detection;

   localparam int FRAME_LEN = 640;
   // Preamble starting at cycle c0 qualifies from sample 31; the 24th qualifying sample is 54, so FrameEnable is high from c0+57.
   localparam int RISE_LAT  = 57;

   logic              Clk = 1'b0;
   logic              Rst;
   logic signed [7:0] bitInR;
   logic signed [7:0] bitInI;
   logic              FrameEnable;
   logic signed [7:0] bitOutR;
   logic signed [7:0] bitOutI;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int rise_at  = -1;
   logic signed [7:0] q_r [4];
   logic signed [7:0] q_i [4];
   logic [15:0] pat_r = 16'hA5C3;
   logic [15:0] pat_i = 16'h3C96;

   frame_detection dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .bitInR      (bitInR),
      .bitInI      (bitInI),
      .FrameEnable (FrameEnable),
      .bitOutR     (bitOutR),
      .bitOutI     (bitOutI)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, expv);
      end
   endtask

   function automatic logic signed [7:0] rnd();
      int v;
      v = int'($urandom_range(254)) - 127;
      return 8'(v);
   endfunction

   function automatic logic signed [7:0] pre_r(input int n, input int amp);
      return pat_r[n % 16] ? 8'(amp) : 8'(-amp);
   endfunction

   function automatic logic signed [7:0] pre_i(input int n, input int amp);
      return pat_i[n % 16] ? 8'(amp) : 8'(-amp);
   endfunction

   // Check this cycle's outputs, then drive the sample that the next rising edge consumes.
   task automatic step(input logic rst, input logic signed [7:0] r, input logic signed [7:0] i);
      logic exp_fe;
      @(negedge Clk);
      exp_fe = (rise_at >= 0) && (cyc >= rise_at) && (cyc < rise_at + FRAME_LEN);
      check("frame_enable", FrameEnable, exp_fe);
      check("bit_out_r", bitOutR, q_r[3]);
      check("bit_out_i", bitOutI, q_i[3]);
      Rst    = rst;
      bitInR = r;
      bitInI = i;
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            q_r[k] = '0;
            q_i[k] = '0;
         end
         rise_at = -1;
      end else begin
         for (int k = 3; k > 0; k--) begin
            q_r[k] = q_r[k-1];
            q_i[k] = q_i[k-1];
         end
         q_r[0] = r;
         q_i[0] = i;
      end
      cyc++;
   endtask

   task automatic do_reset(input int n);
      repeat (n) step(1'b1, rnd(), rnd());
   endtask

   // tail_mode: 0 = zeros after the preamble, 1 = random data after the preamble.
   task automatic run_preamble(input int amp, input int pre_len, input int total,
                               input bit expect_det, input bit tail_mode);
      rise_at = expect_det ? cyc + RISE_LAT : -1;
      for (int n = 0; n < total; n++) begin
         if (n < pre_len)   step(1'b0, pre_r(n, amp), pre_i(n, amp));
         else if (tail_mode) step(1'b0, rnd(), rnd());
         else               step(1'b0, 8'sd0, 8'sd0);
      end
   endtask

   initial begin
      bit gate_on;
`ifdef FD_ENERGY_GATE_EN
      gate_on = 1'b1;
`else
      gate_on = 1'b0;
`endif
      for (int k = 0; k < 4; k++) begin
         q_r[k] = '0;
         q_i[k] = '0;
      end
      Rst    = 1'b1;
      bitInR = rnd();
      bitInI = rnd();

      // Reset with random inputs, then outputs must track the input delayed by 4.
      do_reset(10);
      repeat (12) step(1'b0, rnd(), rnd());

      // Constant zero input never qualifies.
      do_reset(2);
      repeat (720) step(1'b0, 8'sd0, 8'sd0);

      // Preamble +-60 then random data: one 640-cycle pulse, no re-trigger.
      do_reset(2);
      run_preamble(60, 160, 760, 1'b1, 1'b1);

      // Uniform random data never detects.
      do_reset(2);
      repeat (720) step(1'b0, rnd(), rnd());

      // One-cycle reset 100 cycles into a frame, then a fresh preamble detects with the same latency.
      do_reset(2);
      rise_at = cyc + RISE_LAT;
      for (int n = 0; n < RISE_LAT + 100; n++) step(1'b0, pre_r(n, 60), pre_i(n, 60));
      step(1'b1, rnd(), rnd());
      run_preamble(60, 160, 720, 1'b1, 1'b1);

      // Amplitude +-1 preamble has P = 32: detected without the energy gate, rejected with it.
      do_reset(2);
      run_preamble(1, 160, 720, !gate_on, 1'b0);

      step(1'b0, 8'sd0, 8'sd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
